// File: rtl/if_stage_pkg.sv
// Shared constants, FSM state type and helpers for the RV32I instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        IF_BOOT       = 2'd0,
        IF_RUN        = 2'd1,
        IF_MISAL_WAIT = 2'd2
    } if_state_e;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: a flush outranks a stall, and a stall outranks a normal load.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_valid_i,
    input  logic        f_misal_i,
    input  logic [31:0] inst_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_exc_misaligned_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] inst_q,  inst_d;
    logic        exc_q,   exc_d;

    // A flushed slot still records f_pc so a bubble carries a meaningful PC.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        exc_d   = exc_q;
        if (flush_i) begin
            valid_d = DISABLE;
            pc_d    = f_pc_i;
            inst_d  = NOP_INST;
            exc_d   = DISABLE;
        end else if (!stall_i) begin
            valid_d = f_valid_i;
            pc_d    = f_pc_i;
            inst_d  = (f_misal_i || !f_valid_i) ? NOP_INST : inst_i;
            exc_d   = f_misal_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= DISABLE;
            pc_q    <= 32'h0000_0000;
            inst_q  <= NOP_INST;
            exc_q   <= DISABLE;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            exc_q   <= exc_d;
        end
    end

    assign id_valid_o          = valid_q;
    assign id_pc_o             = pc_q;
    assign id_inst_o           = inst_q;
    assign id_exc_misaligned_o = exc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC selection, boot/misalignment FSM and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        flush_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_exc_misaligned
);

    if_state_e   state_q, state_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic        f_valid_q, f_valid_d;
    logic        f_misal_q, f_misal_d;
    logic [31:0] nf;
    logic        id_flush;

    // nf is the address whose word imem returns next cycle, so f_pc simply follows nf.
    always_comb begin
        state_d   = state_q;
        f_pc_d    = f_pc_q;
        f_valid_d = f_valid_q;
        f_misal_d = f_misal_q;
        nf        = f_pc_q;
        case (state_q)
            IF_BOOT: begin
                nf        = RESET_PC;
                f_pc_d    = RESET_PC;
                f_valid_d = ENABLE;
                f_misal_d = DISABLE;
                state_d   = IF_RUN;
            end
            IF_RUN: begin
                if (trap_valid)          nf = trap_pc;
                else if (redirect_valid) nf = redirect_pc;
                else if (stall_if)       nf = f_pc_q;
                else                     nf = f_pc_q + 32'd4;
                f_pc_d    = nf;
                f_valid_d = ENABLE;
                if ((trap_valid || redirect_valid) && is_misaligned(nf)) begin
                    f_misal_d = ENABLE;
                    state_d   = IF_MISAL_WAIT;
                end else begin
                    f_misal_d = DISABLE;
                end
            end
            IF_MISAL_WAIT: begin
                // The misaligned slot is held through stalls until decode has consumed it.
                if (trap_valid) begin
                    nf        = trap_pc;
                    f_pc_d    = trap_pc;
                    f_valid_d = ENABLE;
                    f_misal_d = is_misaligned(trap_pc);
                    state_d   = is_misaligned(trap_pc) ? IF_MISAL_WAIT : IF_RUN;
                end else if (!stall_if) begin
                    f_valid_d = DISABLE;
                    f_misal_d = DISABLE;
                end
            end
            default: begin
                state_d = IF_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IF_BOOT;
            f_pc_q    <= RESET_PC;
            f_valid_q <= DISABLE;
            f_misal_q <= DISABLE;
        end else begin
            state_q   <= state_d;
            f_pc_q    <= f_pc_d;
            f_valid_q <= f_valid_d;
            f_misal_q <= f_misal_d;
        end
    end

    assign imem_addr = {nf[31:2], 2'b00};
    assign id_flush  = trap_valid | redirect_valid | flush_id;

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (id_flush),
        .stall_i             (stall_if),
        .f_pc_i              (f_pc_q),
        .f_valid_i           (f_valid_q),
        .f_misal_i           (f_misal_q),
        .inst_i              (imem_rdata),
        .id_valid_o          (id_valid),
        .id_pc_o             (id_pc),
        .id_inst_o           (id_inst),
        .id_exc_misaligned_o (id_exc_misaligned)
    );

    assign id_pc4 = id_pc + 32'd4;

endmodule
